// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions: default widths, the hard-wired zero
// register index and the common address/word typedefs.
package cpu_pkg;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;
    localparam int REG_ZERO   = 0;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0]     word_t;

endpackage : cpu_pkg

// File: rtl/reg_file_wr_demux_if.sv
// Register file port bundle: one write port (we/wa/wd) and two read ports
// (ra1/rd1, ra2/rd2).
//
// Handshake: there is no valid/ready pair. A write is accepted on every
// rising clk edge where we=1 (the file never stalls). Reads are purely
// combinational, so rd1/rd2 are valid in the same cycle as ra1/ra2.
interface reg_file_wr_demux_if #(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int ADDR_W = cpu_pkg::REG_ADDR_W
);
    logic              we;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd;
    logic [ADDR_W-1:0] ra1;
    logic [ADDR_W-1:0] ra2;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;

    // Datapath side: drives addresses and write data, consumes read data.
    modport master (
        output we, wa, wd, ra1, ra2,
        input  rd1, rd2
    );

    // Register file side.
    modport slave (
        input  we, wa, wd, ra1, ra2,
        output rd1, rd2
    );
endinterface : reg_file_wr_demux_if

// File: rtl/wr_decoder.sv
// Write-address decoder: turns the write address into a one-hot load enable
// per register, gated by we. The zero register never gets a load enable, and
// addresses at or beyond NREGS decode to all zeros.
module wr_decoder
    import cpu_pkg::*;
#(
    parameter int ADDR_W = REG_ADDR_W,
    parameter int NREGS  = 32
) (
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_wa,
    output logic [NREGS-1:0]  o_load
);

    // One-hot decode; bit REG_ZERO stays 0 so the zero register is never loaded.
    always_comb begin
        o_load = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (i != REG_ZERO && i_we && i_wa == ADDR_W'(i)) begin
                o_load[i] = 1'b1;
            end
        end
    end

endmodule : wr_decoder

// File: rtl/reg_file_wr_demux.sv
// Register file for the single-cycle datapath: one decoded write port, two
// combinational read ports with optional same-cycle write forwarding.
// Register 0 is not stored; it always reads as 0.
module reg_file_wr_demux
#(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int ADDR_W = cpu_pkg::REG_ADDR_W,
    parameter int NREGS  = 32,
    parameter bit BYPASS = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    reg_file_wr_demux_if.slave   bus
);
    import cpu_pkg::*;

    // Storage for registers 1..NREGS-1; the zero register has no flops.
    logic [DATA_W-1:0] r_regs [REG_ZERO+1:NREGS-1];

    logic [NREGS-1:0]  w_load;
    logic              w_wr_valid;
    logic              w_bypass1;
    logic              w_bypass2;

    // NREGS:1 read select shared by both read ports. Address 0 and addresses
    // beyond the implemented range fall through to 0.
    function automatic logic [DATA_W-1:0] read_sel(
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] regs [REG_ZERO+1:NREGS-1]
    );
        read_sel = '0;
        for (int i = REG_ZERO + 1; i < NREGS; i++) begin
            if (addr == ADDR_W'(i)) begin
                read_sel = regs[i];
            end
        end
    endfunction

    wr_decoder #(
        .ADDR_W (ADDR_W),
        .NREGS  (NREGS)
    ) u_wr_decoder (
        .i_we   (bus.we),
        .i_wa   (bus.wa),
        .o_load (w_load)
    );

    // A write only really lands when exactly one load enable is set, which
    // already excludes we=0, wa=0 and out-of-range addresses.
    assign w_wr_valid = |w_load;

    // Forward the write data only when the write will actually land; reset
    // suppresses forwarding so reads show the stored value during rst.
    assign w_bypass1 = BYPASS && !rst && w_wr_valid && (bus.ra1 == bus.wa);
    assign w_bypass2 = BYPASS && !rst && w_wr_valid && (bus.ra2 == bus.wa);

    assign bus.rd1 = w_bypass1 ? bus.wd : read_sel(bus.ra1, r_regs);
    assign bus.rd2 = w_bypass2 ? bus.wd : read_sel(bus.ra2, r_regs);

    // Register array: reset clears everything and beats any write; otherwise
    // only the register with its load enable set takes wd.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = REG_ZERO + 1; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int i = REG_ZERO + 1; i < NREGS; i++) begin
                if (w_load[i]) begin
                    r_regs[i] <= bus.wd;
                end
            end
        end
    end

endmodule : reg_file_wr_demux

// File: tb/tb_reg_file_wr_demux.sv
// Directed bench for reg_file_wr_demux. Two copies run side by side on the
// same stimulus: one with forwarding enabled, one without.
module tb_reg_file_wr_demux;

    logic clk;
    logic rst;

    int checks;
    int errors;

    // Reference contents of the register file (identical in both copies).
    logic [31:0] model [32];

    reg_file_wr_demux_if #(.DATA_W(32), .ADDR_W(5)) bus_b ();
    reg_file_wr_demux_if #(.DATA_W(32), .ADDR_W(5)) bus_n ();

    reg_file_wr_demux #(
        .DATA_W (32), .ADDR_W (5), .NREGS (32), .BYPASS (1'b1)
    ) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    reg_file_wr_demux #(
        .DATA_W (32), .ADDR_W (5), .NREGS (32), .BYPASS (1'b0)
    ) u_dut_n (
        .clk (clk),
        .rst (rst),
        .bus (bus_n)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive identical stimulus into both copies.
    task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [4:0] ra1, input logic [4:0] ra2);
        bus_b.we = we;  bus_b.wa = wa;  bus_b.wd = wd;  bus_b.ra1 = ra1;  bus_b.ra2 = ra2;
        bus_n.we = we;  bus_n.wa = wa;  bus_n.wd = wd;  bus_n.ra1 = ra1;  bus_n.ra2 = ra2;
    endtask

    // Change only the read addresses.
    task automatic set_ra(input logic [4:0] ra1, input logic [4:0] ra2);
        bus_b.ra1 = ra1;  bus_b.ra2 = ra2;
        bus_n.ra1 = ra1;  bus_n.ra2 = ra2;
    endtask

    // Advance past one rising edge and settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Check all four read ports: bypass copy (b1,b2) and plain copy (n1,n2).
    task automatic chk4(input string tag, input logic [31:0] eb1, input logic [31:0] eb2,
                        input logic [31:0] en1, input logic [31:0] en2);
        chk({tag, "_byp_rd1"}, bus_b.rd1, eb1);
        chk({tag, "_byp_rd2"}, bus_b.rd2, eb2);
        chk({tag, "_nobyp_rd1"}, bus_n.rd1, en1);
        chk({tag, "_nobyp_rd2"}, bus_n.rd2, en2);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 32; i++) model[i] = 32'h0;

        // Reset for one edge, with a pending write that must be ignored.
        rst = 1'b1;
        drive(1'b1, 5'd3, 32'hCAFE_F00D, 5'd0, 5'd0);
        #2;
        tick();
        rst = 1'b0;
        drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);

        // 1. Every address reads 0 on both ports after reset.
        for (int a = 0; a < 32; a++) begin
            set_ra(5'(a), 5'(31 - a));
            #1;
            chk($sformatf("reset_a%0d", a), bus_b.rd1, 32'h0);
            chk($sformatf("reset_b%0d", a), bus_b.rd2, 32'h0);
            chk($sformatf("reset_c%0d", a), bus_n.rd1, 32'h0);
            chk($sformatf("reset_d%0d", a), bus_n.rd2, 32'h0);
        end

        // 2. Write reg5, read reg5 and untouched reg4.
        drive(1'b1, 5'd5, 32'hDEAD_BEEF, 5'd1, 5'd2);
        tick();
        model[5] = 32'hDEAD_BEEF;
        drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd4);
        #1;
        chk4("wr5", 32'hDEAD_BEEF, 32'h0, 32'hDEAD_BEEF, 32'h0);

        // 3. Write to register 0 is dropped and never forwarded.
        drive(1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
        #1;
        chk4("r0_during", 32'h0, 32'h0, 32'h0, 32'h0);
        tick();
        drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd5);
        #1;
        chk4("r0_after", 32'h0, 32'hDEAD_BEEF, 32'h0, 32'hDEAD_BEEF);

        // 4. Forwarding on both ports at once vs old value without forwarding.
        drive(1'b1, 5'd7, 32'h0000_0011, 5'd0, 5'd0);
        tick();
        model[7] = 32'h11;
        drive(1'b1, 5'd7, 32'h0000_0022, 5'd7, 5'd7);
        #1;
        chk4("byp_before", 32'h22, 32'h22, 32'h11, 32'h11);
        tick();
        model[7] = 32'h22;
        bus_b.we = 1'b0;
        bus_n.we = 1'b0;
        #1;
        chk4("byp_after", 32'h22, 32'h22, 32'h22, 32'h22);

        // Forwarding on one port only; the other port reads a stored register.
        drive(1'b1, 5'd3, 32'h0000_A5A5, 5'd3, 5'd5);
        #1;
        chk4("byp_one", 32'hA5A5, model[5], model[3], model[5]);
        tick();
        model[3] = 32'hA5A5;
        drive(1'b0, 5'd0, 32'h0, 5'd3, 5'd7);
        #1;
        chk4("byp_one_after", 32'hA5A5, 32'h22, 32'hA5A5, 32'h22);

        // 5. Reset beats a simultaneous write; no forwarding while rst=1.
        drive(1'b1, 5'd9, 32'h0000_0055, 5'd0, 5'd0);
        tick();
        model[9] = 32'h55;
        rst = 1'b1;
        drive(1'b1, 5'd9, 32'h0000_1234, 5'd9, 5'd9);
        #1;
        chk4("rst_nobyp", 32'h55, 32'h55, 32'h55, 32'h55);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        drive(1'b0, 5'd0, 32'h0, 5'd9, 5'd7);
        #1;
        chk4("rst_beats_wr", 32'h0, 32'h0, 32'h0, 32'h0);
        set_ra(5'd5, 5'd3);
        #1;
        chk4("rst_clears", 32'h0, 32'h0, 32'h0, 32'h0);

        // 6. Sweep writes of addr*0x01010101 into 1..31.
        for (int a = 1; a < 32; a++) begin
            drive(1'b1, 5'(a), 32'(a) * 32'h0101_0101, 5'd0, 5'd0);
            tick();
            model[a] = 32'(a) * 32'h0101_0101;
        end

        // Edges with we=0 and random wa/wd must change nothing.
        for (int k = 0; k < 16; k++) begin
            logic [4:0] ra;
            ra = 5'($urandom_range(1, 31));
            drive(1'b0, 5'($urandom_range(0, 31)), $urandom, ra, 5'(31 - ra));
            tick();
            chk4($sformatf("we0_%0d", k), model[ra], model[31 - ra], model[ra], model[31 - ra]);
        end

        // Read everything back on both ports.
        drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        for (int a = 0; a < 32; a++) begin
            set_ra(5'(a), 5'(31 - a));
            #1;
            chk4($sformatf("sweep%0d", a), model[a], model[31 - a], model[a], model[31 - a]);
        end

        // Spot-check hand-computed sweep values.
        set_ra(5'd31, 5'd16);
        #1;
        chk4("sweep_spot", 32'h1F1F_1F1F, 32'h1010_1010, 32'h1F1F_1F1F, 32'h1010_1010);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_reg_file_wr_demux
